// File: rtl/lvda_gate_sequencer_if.sv
// Handshake bundle between the LVDA gate sequencer and its consumer:
// step/sync/hold strobes in, gate/phase selects and word/frame markers out.
interface lvda_gate_sequencer_if #(
  parameter int NUM_GATES  = 7,
  parameter int NUM_PHASES = 3
);
  localparam int GW = ($clog2(NUM_GATES) < 1) ? 1 : $clog2(NUM_GATES);

  logic                  step;
  logic                  sync;
  logic                  hold;
  logic                  ad;
  logic [NUM_GATES-1:0]  gate;
  logic [GW-1:0]         gate_idx;
  logic [NUM_PHASES-1:0] phase;
  logic                  word_end;
  logic                  frame_start;

  modport master (
    output step, sync, hold,
    input  ad, gate, gate_idx, phase, word_end, frame_start
  );

  modport slave (
    input  step, sync, hold,
    output ad, gate, gate_idx, phase, word_end, frame_start
  );
endinterface

// File: rtl/lvda_gate_sequencer.sv
// LVDA gate/phase sequencer: one-hot gate and phase rings, AD half-step and word/frame markers.
// One cycle from step/sync to outputs; hold stalls the advance at (HOLD_GATE, ad=1).
module lvda_gate_sequencer #(
  parameter int NUM_GATES  = 7,
  parameter int NUM_PHASES = 3,
  parameter int HOLD_GATE  = 5
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  lvda_gate_sequencer_if.slave bus
);
  localparam int GW = ($clog2(NUM_GATES) < 1) ? 1 : $clog2(NUM_GATES);
  localparam int PW = ($clog2(NUM_PHASES) < 1) ? 1 : $clog2(NUM_PHASES);

  // Gate counter holds g-1 so it doubles as gate_idx.
  localparam logic [GW-1:0] G_LAST = GW'(NUM_GATES - 1);
  localparam logic [GW-1:0] G_HOLD = GW'(HOLD_GATE - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_PHASES - 1);

  logic          ad_q, ad_d;
  logic [GW-1:0] g_q, g_d;
  logic [PW-1:0] p_q, p_d;
  logic          frame_start_q, frame_start_d;

  logic          g_ok;
  logic          p_ok;
  logic          stall;

  logic [NUM_GATES-1:0]  gate_dec;
  logic [NUM_PHASES-1:0] phase_dec;

  always_comb begin
    g_ok  = 32'(g_q) < 32'(NUM_GATES);
    p_ok  = 32'(p_q) < 32'(NUM_PHASES);
    stall = bus.step & bus.hold & ad_q & (g_q == G_HOLD);

    ad_d          = ad_q;
    g_d           = g_q;
    p_d           = p_q;
    frame_start_d = 1'b0;

    if (bus.sync) begin
      ad_d          = 1'b0;
      g_d           = '0;
      p_d           = '0;
      frame_start_d = 1'b1;
    end else if (bus.step && !(g_ok && p_ok)) begin
      // Upset counter encoding: treat any step as a resync to word start.
      ad_d          = 1'b0;
      g_d           = '0;
      p_d           = '0;
      frame_start_d = 1'b1;
    end else if (stall) begin
      ad_d = ad_q;
    end else if (bus.step) begin
      if (!ad_q) begin
        ad_d = 1'b1;
      end else begin
        ad_d = 1'b0;
        if (g_q == G_LAST) begin
          g_d           = '0;
          p_d           = (p_q == P_LAST) ? '0 : p_q + PW'(1);
          frame_start_d = (p_q == P_LAST);
        end else begin
          g_d = g_q + GW'(1);
        end
      end
    end
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      ad_q          <= 1'b0;
      g_q           <= '0;
      p_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      ad_q          <= ad_d;
      g_q           <= g_d;
      p_q           <= p_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    gate_dec = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      gate_dec[i] = (32'(g_q) == 32'(i));
    end
  end

  always_comb begin
    phase_dec = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      phase_dec[i] = (32'(p_q) == 32'(i));
    end
  end

  assign bus.ad          = ad_q;
  assign bus.gate        = gate_dec;
  assign bus.gate_idx    = g_q;
  assign bus.phase       = phase_dec;
  assign bus.word_end    = ad_q & (g_q == G_LAST);
  assign bus.frame_start = frame_start_q;
endmodule

// File: doc/lvda_gate_sequencer.md
# lvda_gate_sequencer

Parametrised successor to the fixed seven-gate LVDA timing flops. It generates the per-bit-time gate sequence, which is one-hot gate G1..GN. It also generates the half-step alternator AD, the one-hot P-phase ring (PA/PB/PC...), and the word/frame markers. The block sits between the clock-phase generator, which supplies the per-bit-time `step` strobe, and the LVDA channel logic that consumes gate and phase selects. Over the fixed design it adds configurable gate and phase counts, a configurable hold gate, and a synchronous resync input.

## Interface
- `NUM_GATES`, default 7: gates per word; legal range 2..16.
- `NUM_PHASES`, default 3: phases per frame; legal range 2..8.
- `HOLD_GATE`, default 5: gate index (1-based) at which `hold` can stall the sequence; legal range 1..NUM_GATES.

- `SIM_CLK` in 1: single clock; all state updates on the rising edge.
- `SIM_RST` in 1: reset, asynchronous, active-high.
- `step` in 1: one-cycle advance strobe, one per bit time; may be asserted on consecutive cycles.
- `sync` in 1: synchronous resync to word start; has priority over `step` and `hold`.
- `hold` in 1: level input; stalls the sequence at the hold point.
- `ad` out 1: half-step alternator.
- `gate` out NUM_GATES: one-hot current gate; bit 0 = G1.
- `gate_idx` out max(1, ceil(log2(NUM_GATES))): binary gate number minus 1.
- `phase` out NUM_PHASES: one-hot current phase; bit 0 = phase A.
- `word_end` out 1: high while the sequence is at gate N with `ad`=1.
- `frame_start` out 1: one-cycle pulse when the sequence enters gate 1, `ad`=0, phase A.

## Operation
- State is:
  - `ad`
  - gate counter g, range 1..N
  - phase counter p, range 0..P-1
  - `frame_start` register
- All outputs are registered or decoded directly from registers. `word_end`, `gate`, `gate_idx` and `phase` are decodes of registers.
- Reset values: g=1 (`gate`=…0001, `gate_idx`=0), `ad`=0, p=0 (`phase`=…001), `word_end`=0, `frame_start`=0.
- Priority each cycle: sync > stall > step > idle.
  - **sync=1:** g←1, `ad`←0, p←0, `frame_start`←1. This applies regardless of `step` and `hold`.
  - **Stall:** occurs when `step`=1 AND `hold`=1 AND g=HOLD_GATE AND `ad`=1. State is unchanged and `frame_start`←0.
    - `hold` has no effect when `ad`=0, so the 0→1 half-step always proceeds.
  - **step=1, ad=0:** `ad`←1; g and p are unchanged.
  - **step=1, ad=1:** `ad`←0.
    - If g<N: g←g+1.
    - If g=N: g←1 and p←(p+1 mod P). On this path `frame_start`←1 exactly when the new p=0.
  - **Idle (step=0, sync=0):** state is held and `frame_start`←0.
  - `frame_start` is 0 in every cycle not listed above.
- Word length is 2·N steps; frame length is 2·N·P steps.
- Wrap-around:
  - g wraps from N to 1.
  - p wraps from P-1 to 0.
  - There is no illegal state: encodings outside the range are unreachable. If an out-of-range encoding is forced by SEU, the next non-stalled step or sync must return the block to a legal state.
- Reset mid-operation: SIM_RST forces the reset values immediately (asynchronously), independent of SIM_CLK. The first step after deassertion behaves as from word start.

## Timing
- Latency: outputs reflect a `step` or `sync` sampled on edge k immediately after edge k, i.e. one cycle.
- `frame_start` is high for exactly the one cycle following the transition edge.
- `word_end` is high for as long as the block remains at (g=N, `ad`=1), which can be several cycles when `step` is sparse.
- `hold` is sampled only on edges where `step`=1. Releasing `hold` takes effect on the next step.
- No combinational path from any input to any output.
- Gate one-hot and phase one-hot must change glitch-free: each is decoded from a single register set, or implemented directly as one-hot registers.

## Test plan
1. **Reset:** assert SIM_RST with SIM_CLK stopped. Required: `gate`=0000001, `gate_idx`=0, `ad`=0, `phase`=001, `word_end`=0, `frame_start`=0 immediately.
2. **One word, defaults:** apply 14 consecutive steps. Required:
   - `ad` toggles 0,1,0,1,…
   - `gate_idx` walks 0,0,1,1,…,6,6, then 0.
   - `word_end` is high only after step 13.
   - After step 14: `phase`=010 and `frame_start` stays 0.
3. **Full frame:** apply 42 steps with one idle cycle between each. Required:
   - `phase` goes 001→010→100→001.
   - `frame_start` pulses for exactly 1 cycle after step 42 and never earlier.
4. **Hold:** at g=5, `ad`=1, raise `hold` and apply 10 steps. Required: state frozen at `gate_idx`=4, `ad`=1. Then drop `hold` and apply 1 step. Required: `gate_idx`=5, `ad`=0. Also check that raising `hold` at g=5, `ad`=0 still allows advance to `ad`=1.
5. **Sync collision:** at g=4, `ad`=1, phase B, assert `sync` and `step` in the same cycle. Required: `gate_idx`=0, `ad`=0, `phase`=001, `frame_start`=1 for one cycle.
6. **Parameter sweep:** NUM_GATES=2, NUM_PHASES=8, HOLD_GATE=2. Required: a frame takes 32 steps; `gate_idx` width is 1; hold stalls at `gate_idx`=1, `ad`=1.
